// File: rtl/alu4_seq.sv
// alu4_seq: nibble-serial sequencer driving an external combinational alu4 slice.
// A WIDTH-bit command is accepted over a valid/ready handshake, then processed four
// bits per clock (LSB nibble first), with the carry chained between nibbles through
// a flop. The assembled result and final carry are returned over a second handshake.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_a, cmd_b                 WIDTH-bit operands
//   cmd_select, cmd_carry_in     ALU select code and carry into nibble 0
//   alu_a, alu_b, alu_select,
//   alu_carry_in                 drive to the alu4 slice (zero outside RUN)
//   alu_out, alu_carry_out       combinational return from the alu4 slice
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_carry        assembled result and carry of the last nibble
//   busy                         high while a command is in RUN or DONE
module alu4_seq #(
  parameter int unsigned WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_select,
  input  logic             cmd_carry_in,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_select,
  output logic             alu_carry_in,
  input  logic [3:0]       alu_out,
  input  logic             alu_carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             busy
);

  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned IdxW = (Nib > 1) ? $clog2(Nib) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Nib - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        sel_q, sel_d;
  logic              cin_q, cin_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  result_q, result_d;

  // Bit offset of the current nibble (idx * 4).
  logic [IdxW+1:0]   nib_base;
  assign nib_base = {idx_q, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    cin_d        = cin_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    result_d     = result_q;
    alu_a        = 4'h0;
    alu_b        = 4'h0;
    alu_select   = 3'b000;
    alu_carry_in = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          a_d      = cmd_a;
          b_d      = cmd_b;
          sel_d    = cmd_select;
          cin_d    = cmd_carry_in;
          idx_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        alu_a        = a_q[nib_base +: 4];
        alu_b        = b_q[nib_base +: 4];
        alu_select   = sel_q;
        // Nibble 0 takes the command carry; later nibbles take the chained carry.
        alu_carry_in = (idx_q == '0) ? cin_q : carry_q;
        result_d[nib_base +: 4] = alu_out;
        carry_d      = alu_carry_out;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decode from state only; no path from cmd_valid or rsp_ready.
  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign rsp_valid  = (state_q == StDone);
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;

endmodule

// File: tb/tb_alu4_seq.sv
module tb_alu4_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=16 instance signals
  logic        cmd_valid, cmd_ready, cmd_carry_in;
  logic [15:0] cmd_a, cmd_b;
  logic [2:0]  cmd_select;
  logic [3:0]  alu_a, alu_b, alu_out;
  logic [2:0]  alu_select;
  logic        alu_carry_in, alu_carry_out;
  logic        rsp_valid, rsp_ready, rsp_carry, busy;
  logic [15:0] rsp_result;

  // WIDTH=4 instance signals
  logic        cmd_valid4, cmd_ready4, cmd_carry_in4;
  logic [3:0]  cmd_a4, cmd_b4;
  logic [2:0]  cmd_select4;
  logic [3:0]  alu_a4, alu_b4, alu_out4;
  logic [2:0]  alu_select4;
  logic        alu_carry_in4, alu_carry_out4;
  logic        rsp_valid4, rsp_ready4, rsp_carry4, busy4;
  logic [3:0]  rsp_result4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
  } exp16_t;
  exp16_t     q16[$];
  logic [4:0] q4[$];  // {carry, result}

  // Behavioural alu4 slice: 010 add with carry, 000 bitwise AND.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] s, input logic ci);
    case (s)
      3'b010:  return {1'b0, a} + {1'b0, b} + {4'b0000, ci};
      3'b000:  return {1'b0, a & b};
      default: return 5'b0;
    endcase
  endfunction

  assign {alu_carry_out, alu_out}   = alu_model(alu_a, alu_b, alu_select, alu_carry_in);
  assign {alu_carry_out4, alu_out4} = alu_model(alu_a4, alu_b4, alu_select4, alu_carry_in4);

  alu4_seq #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_select(cmd_select), .cmd_carry_in(cmd_carry_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .busy(busy)
  );

  alu4_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_a(cmd_a4), .cmd_b(cmd_b4),
    .cmd_select(cmd_select4), .cmd_carry_in(cmd_carry_in4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_select(alu_select4), .alu_carry_in(alu_carry_in4),
    .alu_out(alu_out4), .alu_carry_out(alu_carry_out4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
    .rsp_carry(rsp_carry4), .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp16_unexpected: got result %h carry %b, expected no response",
                 rsp_result, rsp_carry);
      end else begin
        exp16_t e;
        e = q16.pop_front();
        check("rsp16_result", 32'(rsp_result), 32'(e.res));
        check("rsp16_carry", 32'(rsp_carry), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid4 && rsp_ready4) begin
      if (q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp4_unexpected: got result %h, expected no response", rsp_result4);
      end else begin
        logic [4:0] e;
        e = q4.pop_front();
        check("rsp4_result", 32'(rsp_result4), 32'(e[3:0]));
        check("rsp4_carry", 32'(rsp_carry4), 32'(e[4]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                        input logic ci, input logic push, input logic [15:0] er,
                        input logic ec);
    logic rdy;
    int   n;
    exp16_t e;
    cmd_a = a; cmd_b = b; cmd_select = s; cmd_carry_in = ci; cmd_valid = 1'b1;
    if (push) begin
      e.res = er; e.c = ec;
      q16.push_back(e);
    end
    n = 0;
    do begin
      rdy = cmd_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    #1 cmd_valid = 1'b0;
    if (!rdy) check("accept16_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                       input logic ci, input logic [3:0] er, input logic ec);
    logic rdy;
    int   n;
    cmd_a4 = a; cmd_b4 = b; cmd_select4 = s; cmd_carry_in4 = ci; cmd_valid4 = 1'b1;
    q4.push_back({ec, er});
    n = 0;
    do begin
      rdy = cmd_ready4;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    #1 cmd_valid4 = 1'b0;
    if (!rdy) check("accept4_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain16", q16.size(), 0);
    check("drain4", q4.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  cin_seq;
    logic [15:0] a_val;
    logic [3:0]  nib;
    int          n;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_select = '0; cmd_carry_in = 1'b0;
    cmd_valid4 = 1'b0; cmd_a4 = '0; cmd_b4 = '0; cmd_select4 = '0; cmd_carry_in4 = 1'b0;
    rsp_ready = 1'b1;
    rsp_ready4 = 1'b1;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_cmd_ready4", 32'(cmd_ready4), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 00FF + 0001: carry ripples through nibbles 0 and 1.
    a_val   = 16'h00FF;
    cin_seq = 4'b0110;
    send16(a_val, 16'h0001, 3'b010, 1'b0, 1'b1, 16'h0100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nib = 4'(a_val >> (4 * i));
      check($sformatf("add1_carry_in_nib%0d", i), 32'(alu_carry_in), 32'(cin_seq[i]));
      check($sformatf("add1_alu_a_nib%0d", i), 32'(alu_a), 32'(nib));
      check($sformatf("add1_rsp_valid_low_nib%0d", i), 32'(rsp_valid), 32'd0);
      check($sformatf("add1_busy_nib%0d", i), 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("add1_latency_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add1_done_alu_a_zero", 32'(alu_a), 32'd0);
    check("add1_done_cmd_ready", 32'(cmd_ready), 32'd0);
    drain();

    // FFFF + 0000 + 1: carry propagates through every nibble and out.
    send16(16'hFFFF, 16'h0000, 3'b010, 1'b1, 1'b1, 16'h0000, 1'b1);
    drain();

    // AND: carry stays 0.
    send16(16'hF0F0, 16'hFF00, 3'b000, 1'b0, 1'b1, 16'hF000, 1'b0);
    drain();

    // Backpressure, with a second command waiting on cmd_valid.
    rsp_ready = 1'b0;
    send16(16'h1234, 16'h1111, 3'b010, 1'b0, 1'b1, 16'h2345, 1'b0);
    send16_pending: begin
      exp16_t e;
      cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_select = 3'b010; cmd_carry_in = 1'b0;
      cmd_valid = 1'b1;
      e.res = 16'h0007; e.c = 1'b0;
      q16.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("bp_valid_rise", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_held%0d", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_result_held%0d", i), 32'(rsp_result), 32'h2345);
      check($sformatf("bp_cmd_ready_low%0d", i), 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("bp_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("bp_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("bp_second_accepted_busy", 32'(busy), 32'd1);
    check("bp_second_accepted_cmd_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    cmd_a = 16'hFFFF;  // must not affect the in-flight command
    drain();

    // Asynchronous reset at idx=2 aborts the command.
    send16(16'h0A00, 16'h0000, 3'b010, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("abort_pre_alu_a_idx2", 32'(alu_a), 32'hA);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    check("abort_alu_select", 32'(alu_select), 32'd0);
    check("abort_alu_carry_in", 32'(alu_carry_in), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // WIDTH=4: single nibble, response one cycle after accept.
    send4(4'h9, 4'h8, 3'b010, 1'b0, 4'h1, 1'b1);
    @(negedge clk);
    check("w4_run_rsp_valid", 32'(rsp_valid4), 32'd0);
    @(negedge clk);
    check("w4_done_rsp_valid", 32'(rsp_valid4), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu4_seq.md
# alu4_seq

Nibble-serial sequencer that drives an external `alu4` datapath to perform WIDTH-bit operations, four bits per clock, LSB nibble first. It accepts a command (operands, select, carry-in) over a valid/ready handshake. It presents one operand nibble per cycle on the `alu4` input pins and captures `out`/`carry_out` into a result register, chaining the carry between nibbles through a flop. The completed WIDTH-bit result and final carry are returned over a second valid/ready handshake. It sits between the command source and the combinational `alu4` slice, and is the producer of that slice's inputs.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_a`  in  WIDTH  operand A.
- `cmd_b`  in  WIDTH  operand B.
- `cmd_select`  in  3  ALU select code; passed unchanged to every nibble.
- `cmd_carry_in`  in  1  carry into nibble 0.
- `alu_a`  out  4  to `alu4.a`.
- `alu_b`  out  4  to `alu4.b`.
- `alu_select`  out  3  to `alu4.select`.
- `alu_carry_in`  out  1  to `alu4.carry_in`.
- `alu_out`  in  4  from `alu4.out`; combinational from the `alu_*` outputs.
- `alu_carry_out`  in  1  from `alu4.carry_out`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_result`  out  WIDTH  assembled result.
- `rsp_carry`  out  1  carry_out of the last nibble.
- `busy`  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `cmd_ready`=1; `alu_*` outputs driven to 0.
  - On `cmd_valid && cmd_ready`, register `cmd_a`, `cmd_b`, `cmd_select`, `cmd_carry_in`; clear the nibble index `idx` to 0; clear the result register; go to RUN.
- RUN, combinational drive:
  - `alu_a`=`a_reg[4*idx+:4]`, `alu_b`=`b_reg[4*idx+:4]`, `alu_select`=`sel_reg`.
  - `alu_carry_in` = `cin_reg` when `idx`=0, else `carry_reg`.
- RUN, each edge:
  - `result[4*idx+:4]` <= `alu_out`; `carry_reg` <= `alu_carry_out`.
  - If `idx`=NIB-1, go to DONE; otherwise `idx` <= `idx`+1.
  - The index register is ceil(log2(NIB)) bits wide, minimum 1. It never wraps, because it leaves RUN at NIB-1.
- DONE:
  - `rsp_valid`=1, `rsp_result`=result, `rsp_carry`=`carry_reg`; all held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
  - `cmd_ready`=0 in DONE; a command presented during DONE waits for IDLE.
- `alu_*` outputs are 0 in IDLE and DONE.
- The sequencer never interprets `select`. It always chains `carry_out` into the next nibble's `carry_in`, whatever the operation.
- Reset, including mid-RUN or in DONE, takes effect immediately:
  - FSM to IDLE; all registers, `rsp_valid`, `busy` and `alu_*` outputs to 0.
  - `cmd_ready`=1 after reset.
  - Any in-flight command is discarded with no response.

## Timing
- `cmd_ready`, `rsp_valid` and `busy` are decoded from state only. No combinational path from `cmd_valid` or `rsp_ready` to any output.
- Command accepted on edge E0. RUN spans the cycles after E0 through edge E0+NIB; `rsp_valid` rises immediately after edge E0+NIB.
- Latency from command acceptance to `rsp_valid` is NIB cycles (4 for WIDTH=16).
- Minimum command spacing is NIB+2 cycles: NIB RUN cycles, one DONE cycle with immediate `rsp_ready`, one IDLE cycle.
- `alu4` is purely combinational. Its full ripple path (4 slices) plus the capture setup must fit one `clk` period.
- `cmd_*` is sampled only at the accept edge. Later changes have no effect.

## Test plan
Bench `alu4` behavioural model: select 3'b010 → {carry,out} = a+b+cin; select 3'b000 → out = a&b, carry 0.
- WIDTH=16, A=16'h00FF, B=16'h0001, sel=010, cin=0 → after 4 cycles `rsp_result`=16'h0100, `rsp_carry`=0; `alu_carry_in` observed 0,1,1,0 across nibbles 0..3.
- A=16'hFFFF, B=16'h0000, cin=1, sel=010 → `rsp_result`=16'h0000, `rsp_carry`=1.
- A=16'hF0F0, B=16'hFF00, sel=000 → `rsp_result`=16'hF000, `rsp_carry`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → result stable, `cmd_ready`=0 throughout. With `cmd_valid` held high, the second command is accepted exactly one cycle after the `rsp_ready` handshake.
- Assert `rst` asynchronously at RUN `idx`=2 → `busy`, `rsp_valid` and `alu_*` go to 0 with no clock edge; `cmd_ready`=1; no response ever appears for the aborted command.
- WIDTH=4, A=4'h9, B=4'h8, cin=0, sel=010 → `rsp_valid` one cycle after accept; `rsp_result`=4'h1, `rsp_carry`=1.
